sync_fifo_param: RTL

//  Parametrised single-clock FIFO: successor to the fixed 8x16 dual-port FIFO memory wrapper.

---
 rtl/sync_fifo_param_pkg.sv | 27 ++
 rtl/sync_dp_ram.sv | 32 +++
 rtl/sync_fifo_param.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared helpers for the parametrised single-clock FIFO.
// Holds the log2 helper and the level-parameter range check.
package sync_fifo_param_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Legal thresholds: 1 <= af <= depth, 0 <= ae <= depth-1.
    function automatic bit lvls_ok(
        input int addr_w,
        input int af,
        input int ae,
        input int fwft
    );
        int depth;
        depth = 1 << addr_w;
        return (af >= 1) && (af <= depth) &&
               (ae >= 0) && (ae <= depth - 1) &&
               (fwft == 0 || fwft == 1) &&
               (clog2(depth) == addr_w);
    endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clk/rst_n, we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o.
module sync_dp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Only the read register is reset; it holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level flags, sticky errors, optional FWFT.
// Ports: clk, rst_n, wr_en/wr_data, rd_en, clr_err in; rd_data, rd_valid, flags, count out.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int            DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    if (!lvls_ok(ADDR_W, AF_LVL, AE_LVL, FWFT)) begin : g_bad_param
        $error("sync_fifo_param: parameter out of range");
    end

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            af_q, af_d;
    logic            ae_q, ae_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            rv_q, rv_d;
    logic            wr_acc;
    logic            rd_acc;
    logic            ram_re;

    always_comb begin
        wr_acc = wr_en & ~full_q;
        if (FWFT != 0) begin
            // RAM read register is the output stage; refill it when
            // it is free or being popped and RAM still holds words.
            rd_acc = rd_en & rv_q;
            ram_re = (wr_ptr_q != rd_ptr_q) & (~rv_q | rd_acc);
            rv_d   = ram_re | (rv_q & ~rd_acc);
        end else begin
            rd_acc = rd_en & ~empty_q;
            ram_re = rd_acc;
            rv_d   = rd_acc;
        end

        wr_ptr_d = wr_acc ? wr_ptr_q + ONE_C : wr_ptr_q;
        rd_ptr_d = ram_re ? rd_ptr_q + ONE_C : rd_ptr_q;

        count_d = count_q;
        unique case (1'b1)
            (wr_acc & ~rd_acc): count_d = count_q + ONE_C;
            (rd_acc & ~wr_acc): count_d = count_q - ONE_C;
            default:            count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // Setting beats clearing in the same cycle.
        ovf_d = (wr_en & full_q)  | (ovf_q & ~clr_err);
        udf_d = (rd_en & empty_q) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rv_q     <= rv_d;
        end
    end

    sync_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

    assign rd_valid     = rv_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
